// File: rtl/ps2_direction_ctrl_if.sv
// Scancode input and direction output bundle between the PS/2 front end and the sprite mover.
interface ps2_direction_ctrl_if;
    logic [7:0] key_data;
    logic       key_pressed;
    logic       enable;
    logic [3:0] held;
    logic [3:0] step;
    logic       busy_ext;

    modport master (
        output key_data, key_pressed, enable,
        input  held, step, busy_ext
    );

    modport slave (
        input  key_data, key_pressed, enable,
        output held, step, busy_ext
    );
endinterface

// File: rtl/ps2_direction_ctrl.sv
// Arrow-key scancode sequencer: held state plus rate-limited step pulses (WASD via PS2_WASD_KEYS_EN).
// Latency: held/step update on the edge that samples the final scancode strobe (1 cycle).
// Backpressure: none; every key_pressed strobe is consumed, enable only gates step pulses.
module ps2_direction_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic                  clock,
    input  logic                  resetn,
    ps2_direction_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_e;

    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Direction vectors are {up, down, left, right}.
    function automatic logic [3:0] arrow_dir(input logic [7:0] code);
        case (code)
            8'h75:   arrow_dir = 4'b1000;
            8'h72:   arrow_dir = 4'b0100;
            8'h6B:   arrow_dir = 4'b0010;
            8'h74:   arrow_dir = 4'b0001;
            default: arrow_dir = 4'b0000;
        endcase
    endfunction

`ifdef PS2_WASD_KEYS_EN
    function automatic logic [3:0] wasd_dir(input logic [7:0] code);
        case (code)
            8'h1D:   wasd_dir = 4'b1000;
            8'h1B:   wasd_dir = 4'b0100;
            8'h1C:   wasd_dir = 4'b0010;
            8'h23:   wasd_dir = 4'b0001;
            default: wasd_dir = 4'b0000;
        endcase
    endfunction
`endif

    // Opposing keys on one axis cancel, so a step never fires both ways at once.
    function automatic logic [3:0] eff_dir(input logic [3:0] h);
        eff_dir = {h[3] & ~h[2], h[2] & ~h[3], h[1] & ~h[0], h[0] & ~h[1]};
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       held_q, held_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_ext_q, busy_ext_d;
    logic [3:0]       make_dir, brk_dir, new_dir;
    logic             kbd_err;

    always_comb begin
        state_d  = state_q;
        make_dir = 4'b0000;
        brk_dir  = 4'b0000;
        kbd_err  = 1'b0;
        if (bus.key_pressed) begin
            state_d = ST_IDLE;
            if (bus.key_data == 8'h00 || bus.key_data == 8'hFF) begin
                kbd_err = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.key_data == 8'hE0)      state_d = ST_EXT;
                        else if (bus.key_data == 8'hF0) state_d = ST_BRK;
`ifdef PS2_WASD_KEYS_EN
                        else                            make_dir = wasd_dir(bus.key_data);
`endif
                    end
                    ST_EXT: begin
                        if (bus.key_data == 8'hF0) state_d = ST_EXT_BRK;
                        else                       make_dir = arrow_dir(bus.key_data);
                    end
                    ST_BRK: begin
`ifdef PS2_WASD_KEYS_EN
                        brk_dir = wasd_dir(bus.key_data);
`endif
                    end
                    ST_EXT_BRK: brk_dir = arrow_dir(bus.key_data);
                    default:    state_d = ST_IDLE;
                endcase
            end
        end

        // Typematic re-makes of an already-held key leave the cadence alone.
        new_dir = make_dir & ~held_q;
        held_d  = (held_q | make_dir) & ~brk_dir;
        cnt_d   = cnt_q;
        step_d  = 4'b0000;

        if (kbd_err) begin
            held_d = 4'b0000;
            cnt_d  = '0;
        end else if (new_dir != 4'b0000) begin
            step_d = new_dir & eff_dir(held_d);
            cnt_d  = DELAY_LD;
        end else if (held_d == 4'b0000) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_ONE) begin
            step_d = eff_dir(held_d);
            cnt_d  = PERIOD_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // The counter keeps running while disabled so re-enable does not burst.
        step_d     = step_d & {4{bus.enable}};
        busy_ext_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            held_q     <= 4'b0000;
            step_q     <= 4'b0000;
            cnt_q      <= '0;
            busy_ext_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            busy_ext_q <= busy_ext_d;
        end
    end

    assign bus.held     = held_q;
    assign bus.step     = step_q;
    assign bus.busy_ext = busy_ext_q;

endmodule

// File: tb/tb_ps2_direction_ctrl.sv
// Scoreboard bench: expected step pulses are queued with their cycle and matched every clock.
module tb_ps2_direction_ctrl;

    logic clock;
    logic resetn;

    ps2_direction_ctrl_if bus();

    ps2_direction_ctrl #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .CNT_W         (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Advance one edge and reconcile the step output against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL step_missing cyc=%0d got none required=%b", e.cyc, e.val);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.step !== e.val) begin
                miscompares++;
                $display("FAIL step_value cyc=%0d got=%b required=%b", cyc, bus.step, e.val);
            end
        end else if (bus.step !== 4'b0000) begin
            vectors++;
            miscompares++;
            $display("FAIL step_unexpected cyc=%0d got=%b required=0000", cyc, bus.step);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.key_data    = b;
        bus.key_pressed = 1'b1;
        tick();
        bus.key_pressed = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic reset_dut();
        resetn          = 1'b0;
        bus.key_pressed = 1'b0;
        bus.key_data    = 8'h00;
        bus.enable      = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.key_pressed = 1'b0;
        bus.key_data    = 8'h00;
        bus.enable      = 1'b1;
        repeat (2) tick();
        vectors++;
        if (bus.held !== 4'b0000 || bus.busy_ext !== 1'b0 || bus.step !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state got held=%b busy=%b step=%b required 0000/0/0000",
                     bus.held, bus.busy_ext, bus.step);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_left();
        int n;
        reset_dut();
        strobe(8'hE0);
        vectors++;
        if (bus.busy_ext !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_after_e0 got=%b required=1", bus.busy_ext);
        end
        push(cyc + 1, 4'b0010);
        strobe(8'h6B);
        n = cyc;
        vectors++;
        if (bus.held !== 4'b0010 || bus.busy_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL single_held got held=%b busy=%b required 0010/0", bus.held, bus.busy_ext);
        end
        push(n + 8, 4'b0010);
        push(n + 12, 4'b0010);
        push(n + 16, 4'b0010);
        wait_to(n + 16);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        vectors++;
        if (bus.held !== 4'b0000 || bus.busy_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release got held=%b busy=%b required 0000/0", bus.held, bus.busy_ext);
        end
        wait_to(cyc + 50);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_opposing();
        int n;
        reset_dut();
        strobe(8'hE0);
        push(cyc + 1, 4'b0010);
        strobe(8'h6B);
        strobe(8'hE0);
        strobe(8'h74);
        n = cyc;
        vectors++;
        if (bus.held !== 4'b0011) begin
            miscompares++;
            $display("FAIL opposing_held got=%b required=0011", bus.held);
        end
        push(n + 16, 4'b0001);
        push(n + 20, 4'b0001);
        wait_to(n + 10);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        vectors++;
        if (bus.held !== 4'b0001) begin
            miscompares++;
            $display("FAIL opposing_left_release got=%b required=0001", bus.held);
        end
        wait_to(n + 20);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h74);
        vectors++;
        if (bus.held !== 4'b0000) begin
            miscompares++;
            $display("FAIL opposing_all_release got=%b required=0000", bus.held);
        end
        wait_to(cyc + 20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL opposing_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_typematic();
        int n;
        reset_dut();
        strobe(8'hE0);
        push(cyc + 1, 4'b1000);
        strobe(8'h75);
        n = cyc;
        push(n + 8, 4'b1000);
        push(n + 12, 4'b1000);
        push(n + 16, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            strobe(8'hE0);
            strobe(8'h75);
        end
        vectors++;
        if (bus.held !== 4'b1000) begin
            miscompares++;
            $display("FAIL typematic_held got=%b required=1000", bus.held);
        end
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        vectors++;
        if (bus.held !== 4'b0000) begin
            miscompares++;
            $display("FAIL typematic_release got=%b required=0000", bus.held);
        end
        wait_to(cyc + 20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL typematic_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_error_and_async_reset();
        reset_dut();
        strobe(8'hE0);
        push(cyc + 1, 4'b0100);
        strobe(8'h72);
        strobe(8'hFF);
        vectors++;
        if (bus.held !== 4'b0000 || bus.busy_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL error_ff got held=%b busy=%b required 0000/0", bus.held, bus.busy_ext);
        end
        wait_to(cyc + 12);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL error_drain got %0d pending required 0", exp_q.size());
        end
        strobe(8'hE0);
        push(cyc + 1, 4'b0100);
        strobe(8'h72);
        strobe(8'hE0);
        vectors++;
        if (bus.held !== 4'b0100 || bus.busy_ext !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_e0_state got held=%b busy=%b required 0100/1", bus.held, bus.busy_ext);
        end
        #1;
        resetn = 1'b0;
        #1;
        vectors++;
        if (bus.held !== 4'b0000 || bus.busy_ext !== 1'b0 || bus.step !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset got held=%b busy=%b step=%b required 0000/0/0000",
                     bus.held, bus.busy_ext, bus.step);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_enable();
        int n;
        reset_dut();
        bus.enable = 1'b0;
        strobe(8'hE0);
        strobe(8'h6B);
        n = cyc;
        vectors++;
        if (bus.held !== 4'b0010) begin
            miscompares++;
            $display("FAIL enable_held got=%b required=0010", bus.held);
        end
        wait_to(n + 9);
        bus.enable = 1'b1;
        push(n + 12, 4'b0010);
        wait_to(n + 12);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h6B);
        wait_to(cyc + 12);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL enable_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_ignored_codes();
        int n;
        reset_dut();
`ifdef PS2_WASD_KEYS_EN
        push(cyc + 1, 4'b0010);
        strobe(8'h1C);
        vectors++;
        if (bus.held !== 4'b0010) begin
            miscompares++;
            $display("FAIL wasd_make got=%b required=0010", bus.held);
        end
        strobe(8'hF0);
        strobe(8'h1C);
        vectors++;
        if (bus.held !== 4'b0000) begin
            miscompares++;
            $display("FAIL wasd_break got=%b required=0000", bus.held);
        end
`else
        strobe(8'h1C);
        vectors++;
        if (bus.held !== 4'b0000 || bus.busy_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL plain_1c got held=%b busy=%b required 0000/0", bus.held, bus.busy_ext);
        end
`endif
        strobe(8'hE0);
        push(cyc + 1, 4'b1000);
        strobe(8'h75);
        n = cyc;
        push(n + 8, 4'b1000);
        strobe(8'hE0);
        strobe(8'h5A);
        strobe(8'hE1);
        strobe(8'hAA);
        strobe(8'hFA);
        vectors++;
        if (bus.held !== 4'b1000 || bus.busy_ext !== 1'b0) begin
            miscompares++;
            $display("FAIL unknown_codes got held=%b busy=%b required 1000/0", bus.held, bus.busy_ext);
        end
        strobe(8'hF0);
        vectors++;
        if (bus.busy_ext !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_f0 got=%b required=1", bus.busy_ext);
        end
        strobe(8'h6B);
        vectors++;
        if (bus.held !== 4'b1000) begin
            miscompares++;
            $display("FAIL plain_break_ignored got=%b required=1000", bus.held);
        end
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        wait_to(cyc + 15);
        vectors++;
        if (bus.held !== 4'b0000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignored_drain got held=%b pending=%0d required 0000/0", bus.held, exp_q.size());
        end
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_left();
        test_opposing();
        test_typematic();
        test_error_and_async_reset();
        test_enable();
        test_ignored_codes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
